bf_phase_controller: RTL and testbench
======================================

Name: bf_phase_controller

Overview:
- Control unit that drives the address generator of the Bellman-Ford column engine.
- Sequences one relaxation run:
  - distance-memory init sweep
  - read prefetch
  - per-column phase counting
  - iteration counting, with early termination when a whole sweep makes no update
  - negative-cycle detection on the final permitted sweep
- Produces `read_enable_cu`, `write_enable_cu`, `pre_rollover_phase_counter` and `rollover_phase_counter`; consumes `iteration_done`.

Parameters:
- NUM_PHASES, 4, clock cycles spent per column; minimum 2.
- PHASE_W, 2, phase counter width; must satisfy 2^PHASE_W >= NUM_PHASES.
- MAX_ITERATIONS, 32, maximum sweeps = node count (N-1 relaxation sweeps + 1 detection sweep).
- ITER_W, 6, iteration counter width; must hold MAX_ITERATIONS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_global_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  pulse; begins a run from IDLE or DONE, ignored otherwise.
- stop  in  1  synchronous abort; returns to IDLE from any state next cycle.
- update_detected  in  1  OR of PE relax flags, valid any cycle in RUN.
- iteration_done  in  1  address generator flag: write address at last column (combinational).
- init_active  out  1  datapath drives INF write data.
- read_enable_cu  out  1  read-address advance request.
- write_enable_cu  out  1  write-address advance request (init sweep only).
- pre_rollover_phase_counter  out  1  high when phase == NUM_PHASES-2 in RUN.
- rollover_phase_counter  out  1  high when phase == NUM_PHASES-1 in RUN.
- phase_count  out  PHASE_W  current phase.
- iteration_count  out  ITER_W  completed sweeps of the current run.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  high in DONE.
- negative_cycle  out  1  valid while done; held until the next start.

Behaviour:
- Reset:
  - state IDLE; phase_count, iteration_count, changed flag and negative_cycle all 0.
  - All outputs 0.
- Output timing:
  - Every output is a decode of registered state/counters.
  - No output depends combinationally on any input.
- States:
  - IDLE
    - start -> INIT.
    - On the start edge, clear iteration_count, changed flag and negative_cycle.
  - INIT
    - init_active = 1 and write_enable_cu = 1 every cycle.
    - In the cycle iteration_done = 1, the last column is written; next state PRIME.
  - PRIME
    - One cycle only; read_enable_cu = 1 to prefetch column 0.
    - phase_count forced to 0; next state RUN.
  - RUN
    - phase_count increments each cycle and wraps NUM_PHASES-1 -> 0.
    - Rollover outputs are decoded from phase_count.
    - read_enable_cu = 0 and write_enable_cu = 0.
    - changed flag is set on any cycle with update_detected = 1.
  - DONE
    - done = 1 and all enables 0; counters hold.
    - start -> INIT, clearing counters and flags as in IDLE.
- Sweep end (RUN only):
  - Occurs on the cycle where rollover_phase_counter = 1 and iteration_done = 1.
  - Next cycle: iteration_count += 1 and changed flag cleared.
  - Decision on that cycle uses chg = changed flag OR update_detected of the same cycle. An update on the sweep-end cycle belongs to the ending sweep.
    - chg = 0 -> DONE, negative_cycle = 0 (converged early).
    - chg = 1 and iteration_count == MAX_ITERATIONS-1 -> DONE, negative_cycle = 1.
    - Otherwise stay in RUN; phase continues from 0 into the next sweep.
- Wrap-around:
  - The address generator resets its own read/write addresses at the last column.
  - This block issues no address reset.
- Phase counter: counts only in RUN. Otherwise it is held at 0, so both rollover outputs are 0 outside RUN.
- stop:
  - Has priority over start and over every other transition.
  - Next cycle: state IDLE, counters 0, all outputs 0.
  - Aborting a run does not set done.
- Async reset mid-run: all registers clear immediately; no pending sweep-end is recorded.
- start while busy: ignored.
- update_detected outside RUN: ignored.
- iteration_done outside INIT/RUN: ignored.

Test Plan:
1. Reset and init: NUM_PHASES=4; bench models a 3-column address generator; pulse start.
   -> init_active and write_enable_cu high for exactly 3 cycles, then a 1-cycle read_enable_cu, then RUN with phase_count 0,1,2,3,0.
2. Rollover decode.
   -> pre_rollover high on phase 2 only, rollover high on phase 3 only, one cycle each per column; both 0 in IDLE, INIT, PRIME and DONE.
3. Early convergence: update_detected pulsed in sweeps 1 and 2, none in sweep 3.
   -> DONE after the third sweep end; iteration_count = 3; negative_cycle = 0.
4. Negative cycle: MAX_ITERATIONS=4; update_detected every sweep.
   -> DONE after sweep 4; iteration_count = 4; negative_cycle = 1.
5. Boundary update: update_detected high only on a sweep-end cycle.
   -> that sweep counts as changed, and the next sweep's changed flag starts at 0.
6. Abort and reset:
   - stop mid-RUN -> IDLE next cycle, all outputs 0, done = 0.
   - rst_global_n low mid-INIT -> outputs 0 asynchronously, before the next clock edge.
   - start again -> a full, normal run.

Source files
------------

// File: rtl/bf_phase_if.sv
// Handshake/status bundle between the Bellman-Ford phase controller
// and the address generator / datapath it steers.
interface bf_phase_if #(
  parameter int PHASE_W = 2,
  parameter int ITER_W  = 6
);
  logic               start;
  logic               stop;
  logic               update_detected;
  logic               iteration_done;
  logic               init_active;
  logic               read_enable_cu;
  logic               write_enable_cu;
  logic               pre_rollover_phase_counter;
  logic               rollover_phase_counter;
  logic [PHASE_W-1:0] phase_count;
  logic [ITER_W-1:0]  iteration_count;
  logic               busy;
  logic               done;
  logic               negative_cycle;

  modport master (
    input  start, stop, update_detected, iteration_done,
    output init_active, read_enable_cu, write_enable_cu,
    output pre_rollover_phase_counter, rollover_phase_counter,
    output phase_count, iteration_count,
    output busy, done, negative_cycle
  );

  modport slave (
    output start, stop, update_detected, iteration_done,
    input  init_active, read_enable_cu, write_enable_cu,
    input  pre_rollover_phase_counter, rollover_phase_counter,
    input  phase_count, iteration_count,
    input  busy, done, negative_cycle
  );
endinterface

// File: rtl/bf_phase_controller.sv
// Sequencer for one Bellman-Ford relaxation run: init sweep, prefetch,
// phase counting, sweep counting, early exit and negative-cycle flag.
module bf_phase_controller #(
  parameter int NUM_PHASES     = 4,
  parameter int PHASE_W        = 2,
  parameter int MAX_ITERATIONS = 32,
  parameter int ITER_W         = 6
) (
  input logic       clk,
  input logic       rst_global_n,
  bf_phase_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, INIT, PRIME, RUN, DONE
  } state_e;

  localparam logic [PHASE_W-1:0] PH_LAST =
    PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W-1:0] PH_PRE =
    PHASE_W'(NUM_PHASES - 2);
  localparam logic [ITER_W-1:0] IT_LAST =
    ITER_W'(MAX_ITERATIONS - 1);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               chg_q, chg_d;
  logic               neg_q, neg_d;
  logic               init_q, init_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               pre_q, pre_d;
  logic               roll_q, roll_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sweep_end;
  logic               chg_any;

  // Next-state, counters and next-cycle output decode
  always_comb begin
    state_d   = state_q;
    phase_d   = '0;
    iter_d    = iter_q;
    chg_d     = chg_q;
    neg_d     = neg_q;
    sweep_end = (state_q == RUN) && (phase_q == PH_LAST)
                && bus.iteration_done;
    chg_any   = chg_q | bus.update_detected;
    if (bus.stop) begin
      state_d = IDLE;
      iter_d  = '0;
      chg_d   = 1'b0;
      neg_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = INIT;
            iter_d  = '0;
            chg_d   = 1'b0;
            neg_d   = 1'b0;
          end
        end
        INIT: begin
          if (bus.iteration_done) state_d = PRIME;
        end
        PRIME: state_d = RUN;
        RUN: begin
          phase_d = (phase_q == PH_LAST) ? '0
                    : phase_q + 1'b1;
          chg_d   = chg_any;
          if (sweep_end) begin
            iter_d = iter_q + 1'b1;
            chg_d  = 1'b0;
            if (!chg_any) begin
              state_d = DONE;
              neg_d   = 1'b0;
            end else if (iter_q == IT_LAST) begin
              state_d = DONE;
              neg_d   = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    init_d = (state_d == INIT);
    wr_d   = (state_d == INIT);
    rd_d   = (state_d == PRIME);
    pre_d  = (state_d == RUN) && (phase_d == PH_PRE);
    roll_d = (state_d == RUN) && (phase_d == PH_LAST);
    busy_d = (state_d == INIT) || (state_d == PRIME)
             || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_global_n) begin
    if (!rst_global_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      iter_q  <= '0;
      chg_q   <= 1'b0;
      neg_q   <= 1'b0;
      init_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      pre_q   <= 1'b0;
      roll_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      iter_q  <= iter_d;
      chg_q   <= chg_d;
      neg_q   <= neg_d;
      init_q  <= init_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      pre_q   <= pre_d;
      roll_q  <= roll_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.init_active                = init_q;
  assign bus.read_enable_cu             = rd_q;
  assign bus.write_enable_cu            = wr_q;
  assign bus.pre_rollover_phase_counter = pre_q;
  assign bus.rollover_phase_counter     = roll_q;
  assign bus.phase_count                = phase_q;
  assign bus.iteration_count            = iter_q;
  assign bus.busy                       = busy_q;
  assign bus.done                       = done_q;
  assign bus.negative_cycle             = neg_q;

endmodule

// File: tb/tb_bf_phase_controller.sv
// Directed bench: 3-column address generator model, 4 phases,
// sweep limit of 4 so the negative-cycle path is reachable.
module tb_bf_phase_controller;

  logic clk;
  logic rst_n;
  logic [1:0] col;
  int checks;
  int failures;

  bf_phase_if #(.PHASE_W(2), .ITER_W(6)) bus ();

  bf_phase_controller #(
    .NUM_PHASES(4),
    .PHASE_W(2),
    .MAX_ITERATIONS(4),
    .ITER_W(6)
  ) dut (
    .clk(clk),
    .rst_global_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address generator model: column advances on each init write or
  // at each column's last phase; wraps after column 2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) col <= 2'd0;
    else if (!bus.busy) col <= 2'd0;
    else if (bus.write_enable_cu || bus.rollover_phase_counter)
      col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
  end

  assign bus.iteration_done = (col == 2'd2);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_init"}, 32'(bus.init_active), 0);
    chk({tag, "_we"}, 32'(bus.write_enable_cu), 0);
    chk({tag, "_re"}, 32'(bus.read_enable_cu), 0);
    chk({tag, "_pre"}, 32'(bus.pre_rollover_phase_counter), 0);
    chk({tag, "_roll"}, 32'(bus.rollover_phase_counter), 0);
    chk({tag, "_phase"}, 32'(bus.phase_count), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  // Pulse start, then check 3 init cycles and the prime cycle
  task automatic start_run();
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("init_active", 32'(bus.init_active), 1);
      chk("init_we", 32'(bus.write_enable_cu), 1);
      chk("init_re", 32'(bus.read_enable_cu), 0);
      chk("init_roll", 32'(bus.rollover_phase_counter), 0);
      chk("init_pre", 32'(bus.pre_rollover_phase_counter), 0);
      chk("init_iter", 32'(bus.iteration_count), 0);
      chk("init_neg", 32'(bus.negative_cycle), 0);
      chk("init_done", 32'(bus.done), 0);
    end
    @(negedge clk);
    chk("prime_re", 32'(bus.read_enable_cu), 1);
    chk("prime_we", 32'(bus.write_enable_cu), 0);
    chk("prime_init", 32'(bus.init_active), 0);
    chk("prime_phase", 32'(bus.phase_count), 0);
    chk("prime_roll", 32'(bus.rollover_phase_counter), 0);
    chk("prime_busy", 32'(bus.busy), 1);
  endtask

  // One 12-cycle sweep (3 columns x 4 phases)
  task automatic run_sweep(input int exp_iter, input bit upd_mid,
                           input bit upd_end);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("run_phase", 32'(bus.phase_count), k % 4);
      chk("run_pre", 32'(bus.pre_rollover_phase_counter),
          (k % 4 == 2) ? 1 : 0);
      chk("run_roll", 32'(bus.rollover_phase_counter),
          (k % 4 == 3) ? 1 : 0);
      chk("run_iter", 32'(bus.iteration_count), exp_iter);
      chk("run_busy", 32'(bus.busy), 1);
      chk("run_re", 32'(bus.read_enable_cu), 0);
      bus.update_detected = (upd_mid && k == 5) || (upd_end && k == 11);
    end
  endtask

  task automatic check_done(input int exp_iter, input int exp_neg);
    @(negedge clk);
    bus.update_detected = 1'b0;
    chk("done_flag", 32'(bus.done), 1);
    chk("done_iter", 32'(bus.iteration_count), exp_iter);
    chk("done_neg", 32'(bus.negative_cycle), exp_neg);
    chk_quiet("done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.update_detected = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_neg", 32'(bus.negative_cycle), 0);
    chk("rst_iter", 32'(bus.iteration_count), 0);
    chk_quiet("rst");
    rst_n = 1'b1;
    @(negedge clk);
    bus.update_detected = 1'b1;
    @(negedge clk);
    bus.update_detected = 1'b0;
    chk_quiet("idle");

    // Early convergence after sweep 3
    start_run();
    run_sweep(0, 1'b1, 1'b0);
    run_sweep(1, 1'b1, 1'b0);
    run_sweep(2, 1'b0, 1'b0);
    check_done(3, 0);
    @(negedge clk);
    chk("done_hold", 32'(bus.done), 1);
    chk("done_hold_iter", 32'(bus.iteration_count), 3);

    // Update only on the sweep-end cycle
    start_run();
    run_sweep(0, 1'b0, 1'b1);
    run_sweep(1, 1'b0, 1'b0);
    check_done(2, 0);

    // Negative cycle at the sweep limit
    start_run();
    run_sweep(0, 1'b1, 1'b0);
    run_sweep(1, 1'b1, 1'b0);
    run_sweep(2, 1'b1, 1'b0);
    run_sweep(3, 1'b1, 1'b0);
    check_done(4, 1);

    // Restart clears the flag; stop mid-run
    start_run();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.start = (k == 2);
    end
    bus.start = 1'b0;
    chk("pre_stop_phase", 32'(bus.phase_count), 0);
    chk("pre_stop_busy", 32'(bus.busy), 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_done", 32'(bus.done), 0);
    chk("stop_iter", 32'(bus.iteration_count), 0);
    chk("stop_neg", 32'(bus.negative_cycle), 0);
    chk_quiet("stop");

    // Async reset mid-init
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pre_rst_init", 32'(bus.init_active), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", 32'(bus.done), 0);
    chk_quiet("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("post_rst");

    // Full normal run afterwards
    start_run();
    run_sweep(0, 1'b1, 1'b0);
    run_sweep(1, 1'b0, 1'b0);
    check_done(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
